// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace debugger control path.
package trdb_pkg;

  localparam int unsigned XLEN               = 32;
  localparam int unsigned RESYNC_MAX_DEFAULT = 256;

  typedef enum logic [1:0] {
    PKT_START  = 2'd0,
    PKT_STOP   = 2'd1,
    PKT_RESYNC = 2'd2
  } pkt_kind_e;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAIT_QUAL,
    ST_START_PKT,
    ST_TRACING,
    ST_RESYNC_PKT,
    ST_STOP_PKT,
    ST_DEACT
  } trace_ctrl_state_e;

endpackage

// File: rtl/trdb_resync_cnt.sv
// Counts qualified instructions between resync packets; flags the terminal count.
module trdb_resync_cnt #(
  parameter int unsigned MAX = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int unsigned CW = $clog2(MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CW'(MAX - 1));

endmodule

// File: rtl/trdb_trace_ctrl.sv
// Tracing-session sequencer: qualifies retirements and requests START/STOP/RESYNC packets.
module trdb_trace_ctrl #(
  parameter int unsigned XLEN       = trdb_pkg::XLEN,
  parameter int unsigned RESYNC_MAX = trdb_pkg::RESYNC_MAX_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            trace_activated_i,
  input  logic            apply_filters_i,
  input  logic            trace_range_match_i,
  input  logic            trace_priv_match_i,
  input  logic            trace_stop_event_i,
  input  logic            iretire_i,
  input  logic [XLEN-1:0] iaddr_i,
  output logic            pkt_req_o,
  input  logic            pkt_ready_i,
  output logic [1:0]      pkt_type_o,
  output logic [XLEN-1:0] pkt_addr_o,
  output logic            trace_qualified_o,
  output logic            trace_req_deactivate_o,
  output logic            busy_o
);

  import trdb_pkg::*;

  trace_ctrl_state_e state_q, state_d;
  logic              stop_pend_q, stop_pend_d;
  logic              deact_pend_q, deact_pend_d;
  logic [XLEN-1:0]   start_addr_q, start_addr_d;
  logic [XLEN-1:0]   last_addr_q, last_addr_d;
  logic              qual, cnt_en, cnt_clr, cnt_tc;
  pkt_kind_e         pkt_kind;

  assign qual = iretire_i & (~apply_filters_i | (trace_range_match_i & trace_priv_match_i));

  trdb_resync_cnt #(.MAX(RESYNC_MAX)) u_resync_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (cnt_en),
    .clr_i (cnt_clr),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d                = state_q;
    stop_pend_d            = stop_pend_q;
    deact_pend_d           = deact_pend_q;
    start_addr_d           = start_addr_q;
    last_addr_d            = last_addr_q;
    cnt_en                 = 1'b0;
    cnt_clr                = 1'b0;
    pkt_req_o              = 1'b0;
    pkt_kind               = PKT_START;
    pkt_addr_o             = '0;
    trace_qualified_o      = 1'b0;
    trace_req_deactivate_o = 1'b0;

    unique case (state_q)
      ST_OFF: begin
        if (trace_activated_i) state_d = ST_WAIT_QUAL;
      end
      ST_WAIT_QUAL: begin
        if (!trace_activated_i) begin
          state_d = ST_OFF;
        end else if (trace_stop_event_i) begin
          state_d = ST_DEACT;
        end else if (qual) begin
          state_d      = ST_START_PKT;
          start_addr_d = iaddr_i;
        end
      end
      ST_START_PKT: begin
        pkt_req_o  = 1'b1;
        pkt_kind   = PKT_START;
        pkt_addr_o = start_addr_q;
        if (trace_stop_event_i) stop_pend_d = 1'b1;
        if (pkt_ready_i) begin
          // A stop arriving on the handshake cycle counts as pending.
          if (stop_pend_q || trace_stop_event_i || !trace_activated_i) begin
            state_d     = ST_STOP_PKT;
            last_addr_d = start_addr_q;
          end else begin
            state_d = ST_TRACING;
            cnt_clr = 1'b1;
          end
        end
      end
      ST_TRACING: begin
        trace_qualified_o = qual;
        if (qual) begin
          last_addr_d = iaddr_i;
          cnt_en      = 1'b1;
        end
        if (trace_stop_event_i) begin
          state_d     = ST_STOP_PKT;
          stop_pend_d = 1'b1;
        end else if (!trace_activated_i || (iretire_i && !qual)) begin
          state_d = ST_STOP_PKT;
        end else if (qual && cnt_tc) begin
          // last_addr takes iaddr this cycle, so it doubles as the resync address.
          state_d = ST_RESYNC_PKT;
          cnt_clr = 1'b1;
        end
      end
      ST_RESYNC_PKT: begin
        pkt_req_o  = 1'b1;
        pkt_kind   = PKT_RESYNC;
        pkt_addr_o = last_addr_q;
        if (trace_stop_event_i) stop_pend_d = 1'b1;
        if (!trace_activated_i) deact_pend_d = 1'b1;
        if (pkt_ready_i) begin
          if (stop_pend_q || trace_stop_event_i || deact_pend_q || !trace_activated_i) begin
            state_d = ST_STOP_PKT;
          end else begin
            state_d = ST_TRACING;
          end
        end
      end
      ST_STOP_PKT: begin
        pkt_req_o  = 1'b1;
        pkt_kind   = PKT_STOP;
        pkt_addr_o = last_addr_q;
        if (trace_stop_event_i) stop_pend_d = 1'b1;
        if (pkt_ready_i) begin
          deact_pend_d = 1'b0;
          if (stop_pend_q || trace_stop_event_i) begin
            state_d = ST_DEACT;
          end else if (!trace_activated_i || deact_pend_q) begin
            state_d = ST_OFF;
          end else begin
            state_d = ST_WAIT_QUAL;
          end
        end
      end
      ST_DEACT: begin
        trace_req_deactivate_o = 1'b1;
        if (!trace_activated_i) begin
          state_d     = ST_OFF;
          stop_pend_d = 1'b0;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  assign pkt_type_o = pkt_kind;
  assign busy_o     = (state_q != ST_OFF);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_OFF;
      stop_pend_q  <= 1'b0;
      deact_pend_q <= 1'b0;
      start_addr_q <= '0;
      last_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      stop_pend_q  <= stop_pend_d;
      deact_pend_q <= deact_pend_d;
      start_addr_q <= start_addr_d;
      last_addr_q  <= last_addr_d;
    end
  end

endmodule

// File: tb/tb_trdb_trace_ctrl.sv
// Scoreboard bench for trdb_trace_ctrl: directed sessions, packets checked by a monitor.
module tb_trdb_trace_ctrl;

  localparam int unsigned XL = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          act = 1'b0, flt = 1'b0, rng = 1'b0, prv = 1'b0, stp = 1'b0, ret = 1'b0, rdy = 1'b0;
  logic [XL-1:0] addr = '0;
  logic          req, tq, deact, busy;
  logic [1:0]    ptype;
  logic [XL-1:0] paddr;

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          done = 1'b0;

  typedef struct packed {
    logic [1:0]    kind;
    logic [XL-1:0] addr;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [1:0] K_START = 2'd0, K_STOP = 2'd1, K_RESYNC = 2'd2;

  always #5 clk = ~clk;

  trdb_trace_ctrl #(.XLEN(XL), .RESYNC_MAX(4)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .trace_activated_i      (act),
    .apply_filters_i        (flt),
    .trace_range_match_i    (rng),
    .trace_priv_match_i     (prv),
    .trace_stop_event_i     (stp),
    .iretire_i              (ret),
    .iaddr_i                (addr),
    .pkt_req_o              (req),
    .pkt_ready_i            (rdy),
    .pkt_type_o             (ptype),
    .pkt_addr_o             (paddr),
    .trace_qualified_o      (tq),
    .trace_req_deactivate_o (deact),
    .busy_o                 (busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic drive(input logic a, input logic f, input logic r, input logic p,
                       input logic s, input logic rt, input logic [XL-1:0] ad, input logic rd);
    @(posedge clk);
    #1;
    act = a; flt = f; rng = r; prv = p; stp = s; ret = rt; addr = ad; rdy = rd;
    #2;
  endtask

  task automatic push(input logic [1:0] k, input logic [XL-1:0] a);
    exp_t e;
    e.kind = k;
    e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    logic          prev_req = 1'b0;
    logic [1:0]    prev_type = '0;
    logic [XL-1:0] prev_addr = '0;
    exp_t          e;
    while (!done) begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
        continue;
      end
      if (prev_req) check("hold_req_type_addr", {req, ptype, paddr}, {1'b1, prev_type, prev_addr});
      if (!req) check("idle_addr_zero", 64'(paddr), 64'd0);
      if (req && rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pkt", {ptype, paddr}, '1);
        end else begin
          e = exp_q.pop_front();
          check("pkt_type_addr", {ptype, paddr}, {e.kind, e.addr});
        end
      end
      prev_req  = req && !rdy;
      prev_type = ptype;
      prev_addr = paddr;
    end
  endtask

  task automatic stimulus();
    // reset state
    #3;
    check("rst_outputs", {req, tq, deact, busy, ptype, paddr}, '0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // filters off, continuous retirement
    drive(1, 0, 0, 0, 0, 0, 32'h0, 1);
    check("t1_off_busy", 64'(busy), 0);
    drive(1, 0, 0, 0, 0, 1, 32'h100, 1); push(K_START, 32'h100);
    check("t1_wait", {busy, req, tq}, 3'b100);
    drive(1, 0, 0, 0, 0, 1, 32'h104, 1);
    check("t1_start_req", {req, tq}, 2'b10);
    drive(1, 0, 0, 0, 0, 1, 32'h108, 1);
    check("t1_tq_108", 64'(tq), 1);
    drive(1, 0, 0, 0, 0, 1, 32'h10C, 1);
    check("t1_tq_10c", 64'(tq), 1);
    drive(0, 0, 0, 0, 0, 1, 32'h110, 1); push(K_STOP, 32'h110);
    check("t1_tq_110", 64'(tq), 1);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 1);
    check("t1_stop_req", 64'(req), 1);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    check("t1_off", 64'(busy), 0);

    // filters on, range drop, stalled stop
    drive(1, 1, 1, 1, 0, 0, 32'h0, 0);
    drive(1, 1, 1, 1, 0, 1, 32'h110, 0); push(K_START, 32'h110);
    drive(1, 1, 1, 1, 0, 0, 32'h0, 1);
    drive(1, 1, 1, 1, 0, 1, 32'h114, 0);
    drive(1, 1, 1, 1, 0, 1, 32'h118, 0);
    drive(1, 1, 1, 1, 0, 1, 32'h11C, 0);
    check("t2_tq_11c", 64'(tq), 1);
    drive(1, 1, 0, 1, 0, 1, 32'h120, 0); push(K_STOP, 32'h11C);
    check("t2_tq_unmatched", 64'(tq), 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 0, 0, 32'h0, 0);
      check("t2_stall_stop", {req, ptype, paddr}, {1'b1, K_STOP, 32'h11C});
    end
    drive(1, 1, 0, 1, 0, 0, 32'h0, 1);
    drive(1, 1, 0, 1, 0, 0, 32'h0, 0);
    check("t2_wait_qual", {busy, req}, 2'b10);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    check("t2_off", 64'(busy), 0);

    // resync every 4 traced instructions
    drive(1, 0, 0, 0, 0, 0, 32'h0, 1);
    drive(1, 0, 0, 0, 0, 1, 32'h200, 1); push(K_START, 32'h200);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 1);
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0, 0, 0, 1, 32'h200 + 32'(4 * i), 1);
      check("t3_tq_a", 64'(tq), 1);
    end
    push(K_RESYNC, 32'h210);
    drive(1, 0, 0, 0, 0, 1, 32'h214, 1);
    check("t3_resync_not_traced", {req, ptype, tq}, {1'b1, K_RESYNC, 1'b0});
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 1, 32'h218 + 32'(4 * i), 1);
      check("t3_tq_b", 64'(tq), 1);
    end
    push(K_RESYNC, 32'h224);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 1);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0); push(K_STOP, 32'h224);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 1);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    check("t3_off", 64'(busy), 0);

    // stop during START with ready low
    drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
    drive(1, 0, 0, 0, 0, 1, 32'h300, 0); push(K_START, 32'h300);
    drive(1, 0, 0, 0, 1, 0, 32'h0, 0);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 1); push(K_STOP, 32'h300);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 1);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
    check("t4_deact_a", {deact, busy, req}, 3'b110);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
    check("t4_deact_held", 64'(deact), 1);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    check("t4_deact_last", 64'(deact), 1);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    check("t4_off", {deact, busy}, 2'b00);

    // deactivate and stop together in TRACING
    drive(1, 0, 0, 0, 0, 0, 32'h0, 1);
    drive(1, 0, 0, 0, 0, 1, 32'h400, 1); push(K_START, 32'h400);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 1);
    drive(1, 0, 0, 0, 0, 1, 32'h404, 1);
    drive(0, 0, 0, 0, 1, 0, 32'h0, 1); push(K_STOP, 32'h404);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 1);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 1);
    check("t5_deact", {deact, req}, 2'b10);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 1);
    check("t5_off", {deact, busy}, 2'b00);

    // async reset in the middle of STOP_PKT
    drive(1, 0, 0, 0, 0, 0, 32'h0, 1);
    drive(1, 0, 0, 0, 0, 1, 32'h500, 1); push(K_START, 32'h500);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 1);
    drive(0, 0, 0, 0, 0, 1, 32'h504, 0);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    check("t6_stop_req", {req, ptype, paddr}, {1'b1, K_STOP, 32'h504});
    rst = 1'b1;
    #1;
    check("t6_async_rst", {req, busy, paddr}, '0);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    check("t6_off", {req, busy}, 2'b00);

    drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    check("all_pkts_seen", 64'(exp_q.size()), 0);
  endtask

  initial begin
    fork
      monitor();
      begin
        stimulus();
        done = 1'b1;
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
